// File: rtl/uart_frame_codec.sv
// UART byte-stream framing codec.
// RX: hunts for SOF (0xA5), parses LEN/TYPE/payload/CRC and holds a decoded
// frame with a CRC verdict until the consumer takes it.
// TX: accepts a whole frame and serialises SOF/LEN/TYPE/payload/CRC with a
// freshly computed CRC-8 (poly 0x07, init 0x00, MSB-first, no final XOR).
module uart_frame_codec #(
  parameter int MAX_PAYLOAD = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_byte,
  output logic                         frame_valid,
  input  logic                         frame_ready,
  output logic [7:0]                   frame_len,
  output logic [7:0]                   frame_type,
  output logic [MAX_PAYLOAD-1:0][7:0]  frame_payload,
  output logic                         crc_ok,
  input  logic                         txf_valid,
  output logic                         txf_ready,
  input  logic [7:0]                   txf_len,
  input  logic [7:0]                   txf_type,
  input  logic [MAX_PAYLOAD-1:0][7:0]  txf_payload,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [7:0]                   tx_byte
);

  localparam logic [7:0] SOF   = 8'hA5;
  localparam int         IDX_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

  // One-byte CRC-8 update, MSB-first, polynomial x^8 + x^2 + x + 1.
  function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  typedef enum logic [2:0] {RX_HUNT, RX_LEN, RX_TYPE, RX_PAY, RX_CRC, RX_HOLD} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_SOF, TX_LEN, TX_TYPE, TX_PAY, TX_CRC} tx_state_t;

  rx_state_t                  r_rx_state, w_rx_next;
  logic [7:0]                 r_rx_crc;
  logic [7:0]                 r_rx_left;
  logic [IDX_W-1:0]           r_rx_idx;
  logic [7:0]                 r_frame_len;
  logic [7:0]                 r_frame_type;
  logic [MAX_PAYLOAD-1:0][7:0] r_frame_pay;
  logic                       r_crc_ok;
  logic                       w_len_ok;
  logic [7:0]                 w_rx_crc_upd;

  tx_state_t                  r_tx_state, w_tx_next;
  logic [7:0]                 r_tx_crc;
  logic [7:0]                 r_tx_left;
  logic [IDX_W-1:0]           r_tx_idx;
  logic [7:0]                 r_tx_len;
  logic [7:0]                 r_tx_type;
  logic [MAX_PAYLOAD-1:0][7:0] r_tx_pay;
  logic                       w_tx_fire;

  // LEN byte restarts the CRC, so it is folded into a zero seed.
  assign w_len_ok     = ({24'd0, rx_byte} <= 32'(MAX_PAYLOAD));
  assign w_rx_crc_upd = crc8_upd((r_rx_state == RX_LEN) ? 8'h00 : r_rx_crc, rx_byte);

  assign frame_valid   = (r_rx_state == RX_HOLD);
  assign frame_len     = r_frame_len;
  assign frame_type    = r_frame_type;
  assign frame_payload = r_frame_pay;
  assign crc_ok        = r_crc_ok;

  // RX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rx_state <= RX_HUNT;
    else        r_rx_state <= w_rx_next;
  end

  // RX next-state: advances only on received bytes, except the HOLD handshake.
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_HUNT: if (rx_valid && rx_byte == SOF) w_rx_next = RX_LEN;
      RX_LEN:  if (rx_valid) w_rx_next = w_len_ok ? RX_TYPE : RX_HUNT;
      RX_TYPE: if (rx_valid) w_rx_next = (r_frame_len == 8'd0) ? RX_CRC : RX_PAY;
      RX_PAY:  if (rx_valid && r_rx_left == 8'd1) w_rx_next = RX_CRC;
      RX_CRC:  if (rx_valid) w_rx_next = RX_HOLD;
      RX_HOLD: if (frame_ready) w_rx_next = RX_HUNT;
      default: w_rx_next = RX_HUNT;
    endcase
  end

  // RX field capture and running CRC; fields stay put until re-latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_crc     <= '0;
      r_rx_left    <= '0;
      r_rx_idx     <= '0;
      r_frame_len  <= '0;
      r_frame_type <= '0;
      r_frame_pay  <= '0;
      r_crc_ok     <= 1'b0;
    end else if (rx_valid) begin
      case (r_rx_state)
        RX_LEN: begin
          r_frame_len <= rx_byte;
          r_rx_left   <= rx_byte;
          r_rx_idx    <= '0;
          r_rx_crc    <= w_rx_crc_upd;
        end
        RX_TYPE: begin
          r_frame_type <= rx_byte;
          r_rx_crc     <= w_rx_crc_upd;
        end
        RX_PAY: begin
          r_frame_pay[r_rx_idx] <= rx_byte;
          r_rx_crc              <= w_rx_crc_upd;
          r_rx_idx              <= r_rx_idx + 1'b1;
          r_rx_left             <= r_rx_left - 8'd1;
        end
        RX_CRC:  r_crc_ok <= (rx_byte == r_rx_crc);
        default: ;
      endcase
    end
  end

  assign w_tx_fire = tx_valid && tx_ready;

  // TX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tx_state <= TX_IDLE;
    else        r_tx_state <= w_tx_next;
  end

  // TX next-state and byte mux; outputs depend only on registers so they hold under stall.
  always_comb begin
    w_tx_next = r_tx_state;
    txf_ready = 1'b0;
    tx_valid  = 1'b1;
    tx_byte   = 8'h00;
    case (r_tx_state)
      TX_IDLE: begin
        txf_ready = 1'b1;
        tx_valid  = 1'b0;
        if (txf_valid) w_tx_next = TX_SOF;
      end
      TX_SOF: begin
        tx_byte = SOF;
        if (w_tx_fire) w_tx_next = TX_LEN;
      end
      TX_LEN: begin
        tx_byte = r_tx_len;
        if (w_tx_fire) w_tx_next = TX_TYPE;
      end
      TX_TYPE: begin
        tx_byte = r_tx_type;
        if (w_tx_fire) w_tx_next = (r_tx_len == 8'd0) ? TX_CRC : TX_PAY;
      end
      TX_PAY: begin
        tx_byte = r_tx_pay[r_tx_idx];
        if (w_tx_fire && r_tx_left == 8'd1) w_tx_next = TX_CRC;
      end
      TX_CRC: begin
        tx_byte = r_tx_crc;
        if (w_tx_fire) w_tx_next = TX_IDLE;
      end
      default: begin
        tx_valid  = 1'b0;
        w_tx_next = TX_IDLE;
      end
    endcase
  end

  // TX frame latch on acceptance, CRC accumulation on each LEN/TYPE/payload transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_crc  <= '0;
      r_tx_left <= '0;
      r_tx_idx  <= '0;
      r_tx_len  <= '0;
      r_tx_type <= '0;
      r_tx_pay  <= '0;
    end else if (r_tx_state == TX_IDLE) begin
      if (txf_valid) begin
        r_tx_len  <= txf_len;
        r_tx_type <= txf_type;
        r_tx_pay  <= txf_payload;
        r_tx_left <= txf_len;
        r_tx_idx  <= '0;
        r_tx_crc  <= 8'h00;
      end
    end else if (w_tx_fire) begin
      case (r_tx_state)
        TX_LEN, TX_TYPE: r_tx_crc <= crc8_upd(r_tx_crc, tx_byte);
        TX_PAY: begin
          r_tx_crc  <= crc8_upd(r_tx_crc, tx_byte);
          r_tx_idx  <= r_tx_idx + 1'b1;
          r_tx_left <= r_tx_left - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_codec.sv
// Bench for uart_frame_codec with an 8-byte payload store.
module tb_uart_frame_codec;

  localparam int MP = 8;
  typedef logic [MP-1:0][7:0] pay_t;
  typedef struct packed {
    logic       ok;
    logic [7:0] len;
    logic [7:0] typ;
    pay_t       pay;
  } frame_t;
  typedef struct {
    logic [7:0] len;
    logic [7:0] typ;
    pay_t       pay;
    logic [7:0] cxor;
    bit         garbage;
    bit         exp_frame;
  } rxvec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rx_valid, frame_valid, frame_ready, crc_ok;
  logic [7:0] rx_byte, frame_len, frame_type;
  pay_t       frame_payload, txf_payload;
  logic       txf_valid, txf_ready, tx_valid, tx_byte_dummy;
  logic       tx_ready = 1'b1;
  logic [7:0] txf_len, txf_type, tx_byte;

  logic       loop_mode, rand_tx;
  logic       tb_txf_valid;
  logic [7:0] tb_txf_len, tb_txf_type;
  pay_t       tb_txf_pay;

  assign txf_valid   = loop_mode ? frame_valid   : tb_txf_valid;
  assign txf_len     = loop_mode ? frame_len     : tb_txf_len;
  assign txf_type    = loop_mode ? frame_type    : tb_txf_type;
  assign txf_payload = loop_mode ? frame_payload : tb_txf_pay;
  assign tx_byte_dummy = 1'b0;

  uart_frame_codec #(.MAX_PAYLOAD(MP)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid), .rx_byte(rx_byte),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_len(frame_len), .frame_type(frame_type),
    .frame_payload(frame_payload), .crc_ok(crc_ok),
    .txf_valid(txf_valid), .txf_ready(txf_ready),
    .txf_len(txf_len), .txf_type(txf_type), .txf_payload(txf_payload),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_byte(tx_byte)
  );

  int checks = 0;
  int failures = 0;
  frame_t     monq[$];
  frame_t     expq[$];
  logic [7:0] txq[$];
  logic [7:0] fb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference CRC: remainder of (message * x^8) divided by x^8+x^2+x+1.
  function automatic logic [7:0] crc_model(input logic [7:0] msg[$]);
    logic [8:0] rem = '0;
    logic       b;
    for (int i = 0; i <= msg.size(); i++) begin
      for (int k = 7; k >= 0; k--) begin
        b = (i < msg.size()) ? msg[i][k] : 1'b0;
        rem = {rem[7:0], b};
        if (rem[8]) rem = rem ^ 9'h107;
      end
    end
    return rem[7:0];
  endfunction

  function automatic pay_t mask_pay(input pay_t p, input logic [7:0] len);
    pay_t r = '0;
    for (int i = 0; i < MP; i++) if (i < int'(len)) r[i] = p[i];
    return r;
  endfunction

  // Byte image of a frame; payload bytes beyond MP wrap through pay.
  task automatic build_frame(input logic [7:0] len, input logic [7:0] typ, input pay_t pay,
                             input logic [7:0] cx);
    logic [7:0] body[$];
    body = {len, typ};
    for (int i = 0; i < int'(len); i++) body.push_back(pay[i % MP]);
    fb = {8'hA5};
    foreach (body[i]) fb.push_back(body[i]);
    fb.push_back(crc_model(body) ^ cx);
  endtask

  // Frame extraction from a complete byte stream by array scanning.
  task automatic parse_model(input logic [7:0] s[$]);
    int i = 0;
    int len;
    logic [7:0] body[$];
    frame_t fr;
    expq.delete();
    while (i < s.size()) begin
      if (s[i] != 8'hA5 || i + 1 >= s.size()) i++;
      else begin
        len = int'(s[i+1]);
        if (len > MP) i += 2;
        else begin
          body.delete();
          for (int j = 0; j < len + 2; j++) body.push_back(s[i+1+j]);
          fr.len = s[i+1];
          fr.typ = s[i+2];
          fr.pay = '0;
          for (int j = 0; j < len; j++) fr.pay[j] = s[i+3+j];
          fr.ok = (s[i+3+len] == crc_model(body));
          expq.push_back(fr);
          i += len + 4;
        end
      end
    end
  endtask

  task automatic cmp_frame(input string nm, input frame_t a, input frame_t e);
    chk({nm, "_len"}, 64'(a.len), 64'(e.len));
    chk({nm, "_type"}, 64'(a.typ), 64'(e.typ));
    chk({nm, "_pay"}, 64'(mask_pay(a.pay, e.len)), 64'(e.pay));
    chk({nm, "_crcok"}, 64'(a.ok), 64'(e.ok));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_fb(input int gap);
    foreach (fb[i]) begin
      send_byte(fb[i]);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic tx_offer(input logic [7:0] len, input logic [7:0] typ, input pay_t pay);
    int n = 0;
    tb_txf_len = len; tb_txf_type = typ; tb_txf_pay = pay; tb_txf_valid = 1'b1;
    while (!txf_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) chk("tx_offer_timeout", 64'(n), 64'(0));
    @(posedge clk); #1;
    tb_txf_valid = 1'b0;
  endtask

  // Handshake monitors.
  always @(negedge clk) begin
    frame_t fr;
    if (rst_n && frame_valid && frame_ready) begin
      fr.ok = crc_ok; fr.len = frame_len; fr.typ = frame_type; fr.pay = frame_payload;
      monq.push_back(fr);
    end
    if (rst_n && tx_valid && tx_ready) txq.push_back(tx_byte);
  end

  // Stalled TX byte must not move.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_b = '0;
  always @(negedge clk) begin
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("tx_stall_valid", 64'(tx_valid), 64'(1));
        chk("tx_stall_byte", 64'(tx_byte), 64'(prev_b));
      end
      prev_stall = tx_valid && !tx_ready;
      prev_b     = tx_byte;
    end
  end

  always @(posedge clk) begin
    #1;
    tx_ready = rand_tx ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rxvec_t     tbl[6];
    frame_t     ef;
    pay_t       p;
    logic [7:0] s[$];
    int         g[$];
    logic [7:0] sent[$];
    logic [7:0] exb[$];
    logic [7:0] body[$];
    logic [7:0] len, typ, cx;
    int         n;

    for (int i = 0; i < MP; i++) p[i] = 8'(i + 1);
    tbl[0] = '{len: 8'd8, typ: 8'h01, pay: p, cxor: 8'h00, garbage: 1'b0, exp_frame: 1'b1};
    tbl[1] = '{len: 8'd8, typ: 8'h01, pay: p, cxor: 8'h01, garbage: 1'b0, exp_frame: 1'b1};
    tbl[2] = '{len: 8'd0, typ: 8'h07, pay: '0, cxor: 8'h00, garbage: 1'b1, exp_frame: 1'b1};
    tbl[3] = '{len: 8'd9, typ: 8'h02, pay: p, cxor: 8'h00, garbage: 1'b0, exp_frame: 1'b0};
    tbl[4] = '{len: 8'd8, typ: 8'hFF, pay: {8{8'hA5}}, cxor: 8'h00, garbage: 1'b1, exp_frame: 1'b1};
    tbl[5] = '{len: 8'd1, typ: 8'hA5, pay: '0, cxor: 8'h00, garbage: 1'b0, exp_frame: 1'b1};

    rst_n = 1'b0; rx_valid = 1'b0; rx_byte = '0; frame_ready = 1'b1;
    loop_mode = 1'b0; rand_tx = 1'b0; tb_txf_valid = 1'b0;
    tb_txf_len = '0; tb_txf_type = '0; tb_txf_pay = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_frame_valid", 64'(frame_valid), 64'(0));
    chk("rst_crc_ok", 64'(crc_ok), 64'(0));
    chk("rst_frame_len", 64'(frame_len), 64'(0));
    chk("rst_frame_type", 64'(frame_type), 64'(0));
    chk("rst_payload", 64'(frame_payload), 64'(0));
    chk("rst_tx_valid", 64'(tx_valid), 64'(0));
    chk("rst_tx_byte", 64'(tx_byte), 64'(0));
    chk("rst_txf_ready", 64'(txf_ready), 64'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Directed RX vectors.
    for (int t = 0; t < 6; t++) begin
      monq.delete();
      if (tbl[t].garbage) begin
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
      end
      build_frame(tbl[t].len, tbl[t].typ, tbl[t].pay, tbl[t].cxor);
      if (int'(tbl[t].len) > MP) fb[fb.size()-1] = 8'h00;
      send_fb(t % 2);
      idle(3);
      chk($sformatf("rxvec%0d_count", t), 64'(monq.size()), 64'(tbl[t].exp_frame ? 1 : 0));
      if (tbl[t].exp_frame && monq.size() > 0) begin
        ef.len = tbl[t].len; ef.typ = tbl[t].typ;
        ef.pay = mask_pay(tbl[t].pay, tbl[t].len); ef.ok = (tbl[t].cxor == 8'h00);
        cmp_frame($sformatf("rxvec%0d", t), monq[0], ef);
      end
    end

    // Latency: frame_valid in the cycle after the CRC byte, single-cycle pulse.
    monq.delete();
    p = '0; p[0] = 8'h10; p[1] = 8'h20;
    build_frame(8'd2, 8'h03, p, 8'h00);
    send_fb(0);
    @(negedge clk);
    chk("lat_fv_rise", 64'(frame_valid), 64'(1));
    @(negedge clk);
    chk("lat_fv_pulse", 64'(frame_valid), 64'(0));
    @(posedge clk); #1;

    // HOLD with frame_ready low: bytes dropped, outputs hold.
    monq.delete();
    frame_ready = 1'b0;
    build_frame(8'd0, 8'h07, '0, 8'h00);
    send_fb(0);
    idle(3);
    @(negedge clk);
    chk("hold_fv", 64'(frame_valid), 64'(1));
    @(posedge clk); #1;
    p = '0; p[0] = 8'h55;
    build_frame(8'd1, 8'h09, p, 8'h00);
    send_fb(0);
    idle(2);
    chk("hold_fv_kept", 64'(frame_valid), 64'(1));
    chk("hold_type_kept", 64'(frame_type), 64'(8'h07));
    chk("hold_no_hs", 64'(monq.size()), 64'(0));
    frame_ready = 1'b1;
    @(posedge clk); #1;
    send_fb(0);
    idle(3);
    chk("hold_release_count", 64'(monq.size()), 64'(2));
    if (monq.size() == 2) chk("hold_next_type", 64'(monq[1].typ), 64'(8'h09));

    // Loopback RX -> TX.
    monq.delete(); txq.delete();
    loop_mode = 1'b1;
    build_frame(tbl[0].len, tbl[0].typ, tbl[0].pay, 8'h00);
    sent = fb;
    send_fb(0);
    n = 0;
    while (txq.size() < 12 && n < 60) begin @(posedge clk); #1; n++; end
    idle(2);
    chk("loop_count", 64'(txq.size()), 64'(12));
    for (int i = 0; i < 12 && i < txq.size(); i++)
      chk($sformatf("loop_b%0d", i), 64'(txq[i]), 64'(sent[i]));
    loop_mode = 1'b0;

    // TX throughput: SOF the cycle after acceptance, LEN+4 back-to-back bytes.
    for (int t = 0; t < 2; t++) begin
      len = (t == 0) ? 8'd0 : 8'd8;
      tb_txf_len = len; tb_txf_type = 8'h33; tb_txf_pay = p; tb_txf_valid = 1'b1;
      @(posedge clk); #1;
      tb_txf_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("txt%0d_sof_valid", t), 64'(tx_valid), 64'(1));
      chk($sformatf("txt%0d_sof_byte", t), 64'(tx_byte), 64'(8'hA5));
      n = 1;
      while (n < 40) begin
        @(negedge clk);
        if (!tx_valid) break;
        n++;
      end
      chk($sformatf("txt%0d_cycles", t), 64'(n), 64'(int'(len) + 4));
      chk($sformatf("txt%0d_ready_back", t), 64'(txf_ready), 64'(1));
      @(posedge clk); #1;
    end

    // Random TX frames under random backpressure.
    rand_tx = 1'b1;
    for (int t = 0; t < 12; t++) begin
      txq.delete();
      len = 8'($urandom_range(0, MP));
      typ = 8'($urandom_range(0, 255));
      for (int i = 0; i < MP; i++) p[i] = 8'($urandom_range(0, 255));
      body = {len, typ};
      for (int i = 0; i < int'(len); i++) body.push_back(p[i]);
      exb = {8'hA5};
      foreach (body[i]) exb.push_back(body[i]);
      exb.push_back(crc_model(body));
      tx_offer(len, typ, p);
      n = 0;
      while (txq.size() < exb.size() && n < 300) begin @(posedge clk); #1; n++; end
      idle(2);
      chk($sformatf("txr%0d_count", t), 64'(txq.size()), 64'(exb.size()));
      for (int i = 0; i < exb.size() && i < txq.size(); i++)
        chk($sformatf("txr%0d_b%0d", t, i), 64'(txq[i]), 64'(exb[i]));
      while (!txf_ready) begin @(posedge clk); #1; end
    end
    rand_tx = 1'b0;
    idle(2);

    // Random RX stream with garbage, gaps, oversize and corrupted frames.
    s.delete(); g.delete();
    for (int f = 0; f < 30; f++) begin
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) begin
        typ = 8'($urandom_range(0, 255));
        s.push_back((typ == 8'hA5) ? 8'h00 : typ);
        g.push_back($urandom_range(0, 3) == 0 ? 1 : 0);
      end
      len = 8'($urandom_range(0, MP + 1));
      typ = 8'($urandom_range(0, 255));
      for (int i = 0; i < MP; i++) p[i] = 8'($urandom_range(0, 255));
      if (int'(len) > MP) begin
        if (typ == 8'hA5) typ = 8'h5A;
        for (int i = 0; i < MP; i++) if (p[i] == 8'hA5) p[i] = 8'h5A;
      end
      cx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      build_frame(len, typ, p, cx);
      if (int'(len) > MP) fb[fb.size()-1] = 8'h00;
      foreach (fb[i]) begin
        s.push_back(fb[i]);
        g.push_back($urandom_range(0, 3) == 0 ? 1 : 0);
      end
      if (int'(len) <= MP) g[g.size()-1] = 1;
    end
    parse_model(s);
    monq.delete();
    foreach (s[i]) begin
      send_byte(s[i]);
      if (g[i] > 0) idle(g[i]);
    end
    idle(4);
    chk("rxr_count", 64'(monq.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size() && i < monq.size(); i++)
      cmp_frame($sformatf("rxr%0d", i), monq[i], expq[i]);

    // Reset mid-frame after TYPE, then a clean frame.
    monq.delete();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_fv", 64'(frame_valid), 64'(0));
    chk("mrst_len", 64'(frame_len), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    p = '0; p[0] = 8'h11; p[1] = 8'h22; p[2] = 8'h33;
    build_frame(8'd3, 8'h02, p, 8'h00);
    send_fb(0);
    idle(3);
    chk("mrst_count", 64'(monq.size()), 64'(1));
    if (monq.size() > 0) begin
      ef.len = 8'd3; ef.typ = 8'h02; ef.pay = p; ef.ok = 1'b1;
      cmp_frame("mrst", monq[0], ef);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_frame_codec.md
# uart_frame_codec

Byte-level framing layer between the UART byte transceiver and the command/response logic. The receive path hunts for a start-of-frame byte, parses length, type, payload and CRC, and presents a whole decoded frame with a CRC verdict. The transmit path takes a whole frame and serialises it back into a byte stream with a freshly computed CRC. The two paths are independent and share only clock and reset.

## Interface
- MAX_PAYLOAD, default 255: payload storage depth in bytes; legal range 1..255.

- clk  in  1  system clock; everything is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  a received byte is present this cycle; no backpressure.
- rx_byte  in  8  received byte.
- frame_valid  out  1  decoded frame available.
- frame_ready  in  1  consumer accepts the decoded frame.
- frame_len  out  8  decoded LEN.
- frame_type  out  8  decoded TYPE.
- frame_payload  out  8 x MAX_PAYLOAD  decoded payload; entries at index LEN and above are don't-care.
- crc_ok  out  1  received CRC equals the computed CRC.
- txf_valid  in  1  a frame to transmit is offered.
- txf_ready  out  1  the TX path accepts a frame.
- txf_len, txf_type  in  8 each  LEN and TYPE of the frame to send.
- txf_payload  in  8 x MAX_PAYLOAD  payload of the frame to send.
- tx_valid  out  1  tx_byte is valid.
- tx_ready  in  1  the downstream UART TX accepts the byte.
- tx_byte  out  8  outgoing byte.

## Operation
- Frame format: SOF = 0xA5, LEN, TYPE, LEN payload bytes, CRC. Total length is LEN+4 bytes.
- CRC-8 definition:
  - Polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR (check value for ASCII "123456789" is 0xF4).
  - Covers LEN, TYPE and the payload. SOF is excluded.
  - Computed one byte per cycle by a combinational byte-update function.
- RX FSM states: HUNT, LEN, TYPE, PAY, CRC, HOLD. It advances only on cycles where rx_valid is 1.
  - HUNT: a byte equal to 0xA5 moves to LEN. Any other byte is discarded.
  - LEN: latch frame_len, clear the CRC register, then update it with LEN.
    - If LEN > MAX_PAYLOAD, return to HUNT.
    - Otherwise go to TYPE.
  - TYPE: latch frame_type and update the CRC. Go to PAY, or to CRC when LEN = 0.
  - PAY: store the byte at payload[idx], update the CRC and increment idx. After the LEN-th byte, go to CRC.
  - CRC: set crc_ok = (byte == computed CRC), set frame_valid and go to HOLD. A frame with a bad CRC is still delivered, with crc_ok = 0.
  - HOLD: frame_valid stays 1 until frame_valid && frame_ready, then return to HUNT. Bytes arriving while in HOLD are dropped.
- RX data outputs (frame_len, frame_type, frame_payload, crc_ok) stay stable from frame_valid until the next frame's field is latched.
- TX FSM states: IDLE, SOF, LEN, TYPE, PAY, CRC.
  - IDLE: txf_ready = 1. On txf_valid && txf_ready, latch LEN, TYPE and the payload, clear the CRC and go to SOF.
  - Each emitting state drives tx_valid = 1 with its byte.
  - The FSM advances only on tx_valid && tx_ready. The CRC updates on the LEN, TYPE and payload transfers.
  - PAY emits payload[0..LEN-1] in order. When LEN = 0, TYPE goes straight to CRC.
  - CRC emits the accumulated CRC, then returns to IDLE.
- Backpressure rule: tx_byte and tx_valid hold steady while tx_ready is 0.
- Looping RX frame outputs into the TX frame inputs must reproduce the received byte stream exactly.

## Timing
- Reset values:
  - frame_valid = 0, crc_ok = 0, frame_len = 0, frame_type = 0, payload contents = 0.
  - tx_valid = 0, tx_byte = 0, txf_ready = 1.
  - Both FSMs start in HUNT/IDLE.
- A reset asserted mid-frame aborts both paths immediately. No partial frame is ever signalled.
- RX latency: frame_valid rises on the clock edge that samples the CRC byte, so it is visible in the cycle after the CRC byte is presented.
- With frame_ready held at 1, frame_valid is a one-cycle pulse. RX can accept the next SOF in the cycle after the handshake.
- TX throughput: with tx_ready held at 1, one byte per cycle.
  - SOF appears the cycle after frame acceptance.
  - The frame occupies LEN+4 consecutive cycles, and txf_ready returns the cycle after the CRC transfer.
- Boundary cases:
  - LEN = 0: a 4-byte frame, on both RX and TX.
  - LEN = MAX_PAYLOAD: accepted.
  - A byte of 0xA5 inside a frame is data, not a resync point.
  - Gaps in rx_valid anywhere in a frame are tolerated with no timeout.

## Test plan
- RX decode: feed A5 08 01 01..08 then the correct CRC, one byte per cycle. Require frame_valid, crc_ok = 1, len = 8, type = 0x01 and payload = 1..8.
- Loopback: connect the RX frame outputs to the TX frame inputs, with frame_ready = 1 and tx_ready = 1. Require TX to emit the identical 12 bytes in order.
- Bad CRC: send the same frame with the CRC XORed with 0x01. Require frame_valid with crc_ok = 0.
- Resync and limits:
  - Leading garbage 00 FF 12 before A5 must be ignored.
  - LEN = 0 frame A5 00 07 CRC: require frame_valid with len = 0.
  - With MAX_PAYLOAD = 8, LEN = 9 must be dropped.
- TX backpressure: toggle tx_ready randomly. Require the byte sequence to be unchanged and tx_byte stable while stalled.
- Reset mid-frame: assert rst_n = 0 after the TYPE byte, then send a full valid frame. Require exactly one frame_valid, for the second frame.
